// File: rtl/snoop_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snoop_bus_pkg
// Brief    : Shared constants for the MSI snooping bus arbiter: bus op codes,
//            controller state encoding and default widths.
// Revision : 1.0 - initial release
// ============================================================================
package snoop_bus_pkg;

    localparam int NPROC_DEF  = 3;
    localparam int TAG_W_DEF  = 5;
    localparam int DATA_W_DEF = 7;

    typedef logic [1:0] bus_op_t;

    localparam bus_op_t BUS_NONE       = 2'b00;
    localparam bus_op_t BUS_READ_MISS  = 2'b01;
    localparam bus_op_t BUS_WRITE_MISS = 2'b10;
    localparam bus_op_t BUS_INVALIDATE = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BCAST = 3'd1;
    localparam logic [2:0] ST_SNOOP = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
    localparam logic [2:0] ST_MEM   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // An asserted request line carrying op 00 is not a bus request.
    function automatic logic is_bus_op(input bus_op_t op);
        return op != BUS_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snoop_bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin picker. Returns the first set bit of
//            VALID scanning upward from PRIO (mod N) as one-hot and index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] prio,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        logic found;
        int   pos;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(prio) + k) % N;
            if (!found && valid[pos]) begin
                found       = 1'b1;
                onehot[pos] = 1'b1;
                idx         = IDX_W'(pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : snoop_bus_arbiter
// Brief    : Round-robin owner of the MSI snooping bus: broadcasts the winning
//            miss/invalidate, sequences owner writeback and memory access, and
//            returns fill data with a completion pulse.
//            Build option SNOOP_WB_FORWARD_EN forwards writeback data straight
//            to the requester instead of re-reading memory.
// Revision : 1.0 - initial release
// ============================================================================
module snoop_bus_arbiter
    import snoop_bus_pkg::*;
#(
    parameter int NPROC  = NPROC_DEF,
    parameter int TAG_W  = TAG_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NPROC-1:0]        Req,
    input  logic [2*NPROC-1:0]      ReqOp,
    input  logic [TAG_W*NPROC-1:0]  ReqTag,
    input  logic [NPROC-1:0]        SnoopHit,
    input  logic [DATA_W*NPROC-1:0] WbData,
    input  logic [DATA_W-1:0]       MemRData,
    input  logic                    MemReady,
    output logic [NPROC-1:0]        Grant,
    output logic                    BusValid,
    output logic [1:0]              BusOp,
    output logic [TAG_W-1:0]        BusTag,
    output logic                    MemRe,
    output logic                    MemWe,
    output logic [TAG_W-1:0]        MemTag,
    output logic [DATA_W-1:0]       MemWData,
    output logic [DATA_W-1:0]       FillData,
    output logic [NPROC-1:0]        Done,
    output logic                    Next
);

    localparam int IDX_W = (NPROC > 1) ? $clog2(NPROC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPROC - 1);
    localparam logic [IDX_W-1:0] ZERO_IDX = '0;

    logic [2:0]        state_q,   state_d;
    logic [IDX_W-1:0]  prio_q,    prio_d;
    logic [NPROC-1:0]  win_oh_q,  win_oh_d;
    logic [IDX_W-1:0]  win_idx_q, win_idx_d;
    bus_op_t           op_q,      op_d;
    logic [TAG_W-1:0]  tag_q,     tag_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [DATA_W-1:0] fill_q,    fill_d;

    logic [NPROC-1:0]  req_valid;
    logic [NPROC-1:0]  arb_oh;
    logic [IDX_W-1:0]  arb_idx;
    logic [NPROC-1:0]  hit_masked;
    logic [NPROC-1:0]  own_oh;
    logic [IDX_W-1:0]  own_idx;

    generate
        for (genvar i = 0; i < NPROC; i++) begin : g_req_valid
            assign req_valid[i] = Req[i] && is_bus_op(ReqOp[2*i +: 2]);
        end
    endgenerate

    // The requester never snoops its own broadcast.
    assign hit_masked = SnoopHit & ~win_oh_q;

    rr_picker #(.N(NPROC), .IDX_W(IDX_W)) u_arb_pick (
        .valid  (req_valid),
        .prio   (prio_q),
        .onehot (arb_oh),
        .idx    (arb_idx)
    );

    // Same picker from index 0 yields the lowest-index M owner.
    rr_picker #(.N(NPROC), .IDX_W(IDX_W)) u_owner_pick (
        .valid  (hit_masked),
        .prio   (ZERO_IDX),
        .onehot (own_oh),
        .idx    (own_idx)
    );

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        win_oh_d  = win_oh_q;
        win_idx_d = win_idx_q;
        op_d      = op_q;
        tag_d     = tag_q;
        wdata_d   = wdata_q;
        fill_d    = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    win_oh_d  = arb_oh;
                    win_idx_d = arb_idx;
                    op_d      = ReqOp[int'(arb_idx)*2 +: 2];
                    tag_d     = ReqTag[int'(arb_idx)*TAG_W +: TAG_W];
                    state_d   = ST_BCAST;
                end
            end
            ST_BCAST: state_d = ST_SNOOP;
            ST_SNOOP: begin
                if (op_q == BUS_INVALIDATE) begin
                    state_d = ST_DONE;
                end else if (|own_oh) begin
                    wdata_d = WbData[int'(own_idx)*DATA_W +: DATA_W];
                    state_d = ST_WB;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                if (MemReady) begin
`ifdef SNOOP_WB_FORWARD_EN
                    fill_d  = wdata_q;
                    state_d = ST_DONE;
`else
                    state_d = ST_MEM;
`endif
                end
            end
            ST_MEM: begin
                if (MemReady) begin
                    fill_d  = MemRData;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                prio_d  = (win_idx_q == LAST_IDX) ? ZERO_IDX : win_idx_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            prio_q    <= '0;
            win_oh_q  <= '0;
            win_idx_q <= '0;
            op_q      <= BUS_NONE;
            tag_q     <= '0;
            wdata_q   <= '0;
            fill_q    <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            win_oh_q  <= win_oh_d;
            win_idx_q <= win_idx_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            wdata_q   <= wdata_d;
            fill_q    <= fill_d;
        end
    end

    // Moore decode: every output is a function of registered state only.
    logic busy;
    assign busy     = (state_q != ST_IDLE);
    assign Grant    = busy ? win_oh_q : '0;
    assign BusValid = (state_q == ST_BCAST);
    assign BusOp    = busy ? op_q  : BUS_NONE;
    assign BusTag   = busy ? tag_q : '0;
    assign MemWe    = (state_q == ST_WB);
    assign MemRe    = (state_q == ST_MEM);
    assign MemTag   = (MemWe || MemRe) ? tag_q : '0;
    assign MemWData = MemWe ? wdata_q : '0;
    assign FillData = fill_q;
    assign Done     = (state_q == ST_DONE) ? win_oh_q : '0;
    assign Next     = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_snoop_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_snoop_bus_arbiter
// Brief    : Self-checking bench for snoop_bus_arbiter; a transaction-level
//            reference model predicts the per-cycle bus timeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snoop_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  Req = '0;
    logic [5:0]  ReqOp = '0;
    logic [14:0] ReqTag = '0;
    logic [2:0]  SnoopHit = '0;
    logic [20:0] WbData = '0;
    logic [6:0]  MemRData = '0;
    logic        MemReady = 1'b0;
    logic [2:0]  Grant;
    logic        BusValid;
    logic [1:0]  BusOp;
    logic [4:0]  BusTag;
    logic        MemRe;
    logic        MemWe;
    logic [4:0]  MemTag;
    logic [6:0]  MemWData;
    logic [6:0]  FillData;
    logic [2:0]  Done;
    logic        Next;

    int checks   = 0;
    int failures = 0;

    int         prio_m = 0;
    logic [6:0] fill_m = '0;

    snoop_bus_arbiter #(.NPROC(3), .TAG_W(5), .DATA_W(7)) dut (
        .clock    (clock),
        .reset    (reset),
        .Req      (Req),
        .ReqOp    (ReqOp),
        .ReqTag   (ReqTag),
        .SnoopHit (SnoopHit),
        .WbData   (WbData),
        .MemRData (MemRData),
        .MemReady (MemReady),
        .Grant    (Grant),
        .BusValid (BusValid),
        .BusOp    (BusOp),
        .BusTag   (BusTag),
        .MemRe    (MemRe),
        .MemWe    (MemWe),
        .MemTag   (MemTag),
        .MemWData (MemWData),
        .FillData (FillData),
        .Done     (Done),
        .Next     (Next)
    );

    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(Grant), 0);
        chk({tag, "_done"}, 32'(Done), 0);
        chk({tag, "_next"}, 32'(Next), 0);
        chk({tag, "_bus_valid"}, 32'(BusValid), 0);
        chk({tag, "_bus_op"}, 32'(BusOp), 0);
        chk({tag, "_bus_tag"}, 32'(BusTag), 0);
        chk({tag, "_mem_re"}, 32'(MemRe), 0);
        chk({tag, "_mem_we"}, 32'(MemWe), 0);
        chk({tag, "_mem_tag"}, 32'(MemTag), 0);
        chk({tag, "_mem_wdata"}, 32'(MemWData), 0);
        chk({tag, "_fill"}, 32'(FillData), 0);
    endtask

    // Called one step after an active edge; reset takes effect without a clock.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk_all_zero("reset");
        @(negedge clock);
        reset  = 1'b0;
        prio_m = 0;
        fill_m = '0;
    endtask

    // One arbitration round from IDLE. rst_at >= 0 asserts reset in that
    // timeline cycle instead of letting the transaction finish.
    task automatic do_txn(input logic [2:0] req, input logic [5:0] op,
                          input logic [14:0] tag, input logic [2:0] hit,
                          input logic [20:0] wbd, input int wbw, input int memw,
                          input logic [6:0] mrd, input int rst_at);
        logic [2:0] vld;
        logic [2:0] hm;
        int         win;
        int         owner;
        logic [1:0] wop;
        logic [4:0] wtag;
        byte        ph[$];
        bit         lst[$];
        byte        p;

        Req = req; ReqOp = op; ReqTag = tag; WbData = wbd;
        SnoopHit = 3'($urandom); MemReady = 1'($urandom); MemRData = 7'($urandom);
        chk("idle_grant", 32'(Grant), 0);
        chk("idle_bus_op", 32'(BusOp), 0);
        chk("idle_bus_tag", 32'(BusTag), 0);
        chk("idle_fill", 32'(FillData), 32'(fill_m));

        for (int i = 0; i < 3; i++) vld[i] = req[i] && (op[2*i +: 2] != 2'b00);
        if (vld == 3'b000) begin
            @(posedge clock); #1;
            chk("noreq_grant", 32'(Grant), 0);
            chk("noreq_bus_valid", 32'(BusValid), 0);
            return;
        end

        win = -1;
        for (int k = 0; k < 3; k++) begin
            if (win < 0 && vld[(prio_m + k) % 3]) win = (prio_m + k) % 3;
        end
        wop   = op[2*win +: 2];
        wtag  = tag[5*win +: 5];
        owner = 0;

        ph.push_back("B"); lst.push_back(1'b0);
        ph.push_back("S"); lst.push_back(1'b0);
        hm = hit & ~(3'b001 << win);
        if (wop != 2'b11 && hm != 3'b000) begin
            owner = hm[0] ? 0 : (hm[1] ? 1 : 2);
            for (int i = 0; i <= wbw; i++) begin ph.push_back("W"); lst.push_back(i == wbw); end
`ifndef SNOOP_WB_FORWARD_EN
            for (int i = 0; i <= memw; i++) begin ph.push_back("M"); lst.push_back(i == memw); end
`endif
        end else if (wop != 2'b11) begin
            for (int i = 0; i <= memw; i++) begin ph.push_back("M"); lst.push_back(i == memw); end
        end
        ph.push_back("D"); lst.push_back(1'b0);

        for (int k = 0; k < ph.size(); k++) begin
            @(posedge clock); #1;
            p = ph[k];
            chk("grant", 32'(Grant), 32'd1 << win);
            chk("bus_valid", 32'(BusValid), 32'(p == "B"));
            chk("bus_op", 32'(BusOp), 32'(wop));
            chk("bus_tag", 32'(BusTag), 32'(wtag));
            chk("mem_we", 32'(MemWe), 32'(p == "W"));
            chk("mem_re", 32'(MemRe), 32'(p == "M"));
            if (p == "W") begin
                chk("wb_mem_tag", 32'(MemTag), 32'(wtag));
                chk("wb_mem_wdata", 32'(MemWData), 32'(wbd[7*owner +: 7]));
            end
            if (p == "M") chk("rd_mem_tag", 32'(MemTag), 32'(wtag));
            chk("done", 32'(Done), (p == "D") ? (32'd1 << win) : 32'd0);
            chk("next", 32'(Next), 32'(p == "D"));
            chk("fill", 32'(FillData), 32'(fill_m));

            if (k == rst_at) begin
                do_reset();
                return;
            end

            // Later request-line activity must not disturb the latched transaction.
            Req = 3'($urandom); ReqOp = 6'($urandom); ReqTag = 15'($urandom);
            SnoopHit = (p == "S") ? hit : 3'($urandom);
            MemReady = (p == "W" || p == "M") ? lst[k] : 1'($urandom);
            MemRData = (p == "M" && lst[k]) ? mrd : 7'($urandom);
            if (p == "M" && lst[k]) fill_m = mrd;
`ifdef SNOOP_WB_FORWARD_EN
            if (p == "W" && lst[k]) fill_m = wbd[7*owner +: 7];
`endif
            if (p == "D") prio_m = (win + 1) % 3;
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #2;
        chk_all_zero("por");
        @(negedge clock);
        reset = 1'b0;

        // P1 read miss tag 10, memory answers at once with 10.
        do_txn(3'b010, 6'b00_01_00, {5'd0, 5'd10, 5'd0}, 3'b000, '0, 0, 0, 7'd10, -1);
        // P0 write miss tag 18, P1 owns the line with data 19.
        do_txn(3'b001, 6'b00_00_10, {5'd0, 5'd0, 5'd18}, 3'b010, {7'd0, 7'd19, 7'd0}, 1, 0, 7'd19, -1);

        // All three request from reset; pointer then wraps to P0.
        @(posedge clock); #1;
        do_reset();
        do_txn(3'b111, 6'b01_10_01, {5'd3, 5'd2, 5'd1}, 3'b000, '0, 0, 0, 7'd33, -1);
        do_txn(3'b110, 6'b01_10_01, {5'd3, 5'd2, 5'd1}, 3'b000, '0, 0, 1, 7'd44, -1);
        do_txn(3'b100, 6'b01_10_01, {5'd3, 5'd2, 5'd1}, 3'b000, '0, 0, 0, 7'd55, -1);
        do_txn(3'b001, 6'b00_00_01, {5'd0, 5'd0, 5'd4}, 3'b000, '0, 0, 0, 7'd66, -1);

        // P3 invalidate tag 8 with a P0 hit: no memory traffic.
        do_txn(3'b100, 6'b11_00_00, {5'd8, 5'd0, 5'd0}, 3'b001, {7'd0, 7'd0, 7'd99}, 0, 0, 7'd1, -1);
        // Memory stalls 5 cycles in MEM.
        do_txn(3'b100, 6'b01_00_00, {5'd21, 5'd0, 5'd0}, 3'b000, '0, 0, 5, 7'd77, -1);
        // Request with op 00 is ignored.
        do_txn(3'b111, 6'b00_00_00, '0, 3'b000, '0, 0, 0, 7'd0, -1);
        // Reset during MEM, then P1 re-arbitrates from pointer 0.
        do_txn(3'b100, 6'b01_00_00, {5'd9, 5'd0, 5'd0}, 3'b000, '0, 0, 2, 7'd12, 2);
        do_txn(3'b010, 6'b00_01_00, {5'd0, 5'd7, 5'd0}, 3'b000, '0, 0, 0, 7'd88, -1);
        do_txn(3'b011, 6'b00_01_01, {5'd0, 5'd7, 5'd6}, 3'b000, '0, 0, 0, 7'd89, -1);

        for (int n = 0; n < 60; n++) begin
            do_txn(3'($urandom), 6'($urandom), 15'($urandom), 3'($urandom), 21'($urandom),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 7'($urandom), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Owner of the shared snooping bus between the MSI processor caches (P0, P1, P3 on requester indices 0, 1, 2) and main memory. Arbitrates bus requests round-robin and broadcasts the winner's read miss, write miss or invalidate on the bus. Collects snoop responses, sequences the owner writeback and memory access, and returns fill data plus a completion pulse to the requester. Sits in `Snooping` between the cache controllers and the memory model; its `Next` pulse is the per-transaction event the bench prints on.

## Interface
- `NPROC`, 3, number of requesting caches.
- `TAG_W`, 5, address tag width.
- `DATA_W`, 7, data word width.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `Req` in NPROC: per-cache bus request; held until `Done` for that cache.
- `ReqOp` in 2*NPROC: per-cache bus op; slice i = bits [2i+1:2i].
- `ReqTag` in TAG_W*NPROC: per-cache tag.
- `SnoopHit` in NPROC: cache holds the broadcast tag in M.
- `WbData` in DATA_W*NPROC: per-cache data of the M line.
- `MemRData` in DATA_W: memory read data.
- `MemReady` in 1: memory access complete.
- `Grant` out NPROC: one-hot current bus owner.
- `BusValid` out 1: broadcast strobe.
- `BusOp` out 2: broadcast op (`saidaBus`).
- `BusTag` out TAG_W: broadcast tag.
- `MemRe`, `MemWe` out 1: memory read/write strobes.
- `MemTag` out TAG_W: memory tag.
- `MemWData` out DATA_W: memory write data.
- `FillData` out DATA_W: line data for the requester.
- `Done` out NPROC: one-hot completion pulse.
- `Next` out 1: transaction-complete pulse.

## Operation
- Op codes: 00 none, 01 read miss, 10 write miss, 11 invalidate. A `Req` bit with op 00 is not a request.
- Round-robin pointer `Prio`. Winner is the first valid requester scanning `Prio`, `Prio`+1, … modulo NPROC. On DONE, `Prio` becomes winner+1, wrapping NPROC-1 to 0.
- **IDLE**: if any valid request, latch winner, op and tag, then go to BCAST. Otherwise stay.
- **BCAST**: `Grant`[winner]=1, `BusValid`=1, `BusOp`/`BusTag` = latched values. Go to SNOOP.
- **SNOOP**: sample `SnoopHit` with the winner's bit masked.
  - Invalidate: go to DONE; hits are ignored and there is no memory access.
  - Otherwise, any hit: the owner is the lowest-index hitting cache; go to WB.
  - Otherwise: go to MEM.
- **WB**: `MemWe`=1, `MemTag`=tag, `MemWData`=`WbData`[owner]. Hold until `MemReady`, then follow the configured path.
- **MEM**: `MemRe`=1, `MemTag`=tag. When `MemReady` is sampled, latch `FillData`=`MemRData` and go to DONE.
- **DONE**: `Done`[winner]=1 and `Next`=1 for one cycle. Update `Prio`, clear `Grant`, go to IDLE.
- `Grant` is held from BCAST through DONE. `BusOp`/`BusTag` are held stable from BCAST through DONE; they are 0 in IDLE.
- Changes to `Req`, `ReqOp` or `ReqTag` after latching are ignored until IDLE.
- `FillData` holds its last value until overwritten.

## Timing
- All outputs are registered or Moore-decoded from state.
- Reset values: state IDLE, `Prio`=0, every output 0 (`Grant`, `Done`, `Next`, `BusValid`, `BusOp`, `BusTag`, `MemRe`, `MemWe`, `MemTag`, `MemWData`, `FillData`).
- Request sampled at edge 0, no hits, `MemReady` high in the first MEM cycle: BCAST in cycle 1, SNOOP cycle 2, MEM cycle 3, DONE cycle 4.
- Invalidate: DONE in cycle 3.
- Each extra `MemReady`-low cycle adds one cycle.
- The earliest next arbitration is the IDLE cycle after DONE. The bus is never re-granted inside a transaction.
- `MemReady` is sampled only in WB and MEM.
- `reset` asserted in any state: everything returns to reset values immediately. Any in-flight transaction is dropped without `Done`, and requesters re-arbitrate from `Prio`=0.

## Configuration
- `SNOOP_WB_FORWARD_EN` defined: WB completion sets `FillData`=`WbData`[owner] and goes straight to DONE, with no memory read.
- `SNOOP_WB_FORWARD_EN` undefined: WB completion goes to MEM, and the requester receives data re-read from memory.

## Structure
- Package `snoop_bus_pkg`:
  - Op code constants `BUS_NONE`, `BUS_READ_MISS`, `BUS_WRITE_MISS`, `BUS_INVALIDATE`.
  - State encoding IDLE/BCAST/SNOOP/WB/MEM/DONE.
  - Width defaults.
- Sub-module `rr_picker`: combinational. Takes the valid-request vector and `Prio`; returns one-hot winner and index. Reused for the lowest-index owner select with `Prio`=0.

## Test plan
- P1 read miss, tag 10; no hits; `MemRData`=10 with `MemReady` immediate -> `BusOp`=01, `BusTag`=10 in cycle 1; `MemRe` in cycle 3; `Done`[1] and `Next` in cycle 4; `FillData`=10.
- P0 write miss, tag 18; P1 `SnoopHit`=1 with `WbData`=19 -> `MemWe` with tag 18 / data 19.
  - With the macro: `FillData`=19 and no `MemRe`.
  - Without the macro: `MemRe` follows; `MemRData`=19 gives `FillData`=19.
- All three request from reset -> grants in order 0, 1, 2; then P0 re-requests and is granted (pointer wraps from 2 to 0).
- P3 invalidate, tag 8, with P0 `SnoopHit` forced -> no `MemRe`/`MemWe`; `Done`[2] in cycle 3.
- `MemReady` held low 5 cycles in MEM -> state, `Grant` and `BusOp` stable; `Done` in cycle 9.
- `reset` pulsed during MEM -> all outputs 0 the same cycle, no `Done`; after release, a pending P1 request is re-granted from `Prio`=0.
